weight_update_scheduler: RTL and testbench
==========================================

Name: weight_update_scheduler

Overview:
Sequences one layer's weight update through the weight-update point datapath (δ×x → ×LR → w−Δ, 21-cycle fixed latency, in-order results). On start it walks every weight of the layer, reads the old weight, data point and delta from layer memories, and issues one update per slot. It writes each returned new weight back to weight memory and signals done. It sits between the backprop controller and the layer's weight, activation and delta RAMs.

Parameters:
DATA_WIDTH, 32, float word width
NUM_INPUTS, 4, data points per neuron (excluding bias)
NUM_NEURONS, 4, neurons in layer
W_ADDR_WIDTH, 5, weight RAM address width, ≥ clog2(NUM_NEURONS*(NUM_INPUTS+1))
X_ADDR_WIDTH, 3, data-point RAM address width
D_ADDR_WIDTH, 3, delta RAM address width
ISSUE_INTERVAL, 1, min cycles between issues (≥1)
ONE, 'h3F800000, bias data point (1.0)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_start  in  1  begin layer update (1-cycle pulse)
o_busy  out  1  high from accepted start until done
o_done  out  1  1-cycle pulse after final writeback
o_rd_en  out  1  read strobe to all three RAMs
o_w_rd_addr  out  W_ADDR_WIDTH  weight read address
o_x_rd_addr  out  X_ADDR_WIDTH  data-point read address
o_d_rd_addr  out  D_ADDR_WIDTH  delta read address
i_w_rd_data  in  DATA_WIDTH  old weight (valid cycle after o_rd_en)
i_x_rd_data  in  DATA_WIDTH  data point (valid cycle after o_rd_en)
i_d_rd_data  in  DATA_WIDTH  delta (valid cycle after o_rd_en)
o_upd_valid  out  1  issue to datapath
o_old_weight  out  DATA_WIDTH  to datapath
o_data_point  out  DATA_WIDTH  to datapath
o_delta  out  DATA_WIDTH  to datapath
i_upd_valid  in  1  datapath result valid
i_new_weight  in  DATA_WIDTH  datapath result
o_wr_en  out  1  weight write strobe
o_wr_addr  out  W_ADDR_WIDTH  weight write address
o_wr_data  out  DATA_WIDTH  new weight

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. All state and outputs sampled on posedge clk.
- Reset: state IDLE, all counters 0, all outputs 0.
- TOTAL = NUM_NEURONS*(NUM_INPUTS+1). Weight k = n*(NUM_INPUTS+1)+j. j==NUM_INPUTS is the bias.
- FSM: IDLE → ISSUE on i_start. ISSUE → DRAIN after read of k=TOTAL-1. DRAIN → IDLE when writeback count hits TOTAL, with o_done pulsed that cycle.
- ISSUE: o_rd_en=1 every ISSUE_INTERVAL cycles, starting the cycle after start. Addresses are w=k, x=j, d=n. Counters j and n wrap: j resets at NUM_INPUTS and n increments.
- Issue register: cycle after o_rd_en, o_upd_valid=1 with RAM data. o_data_point=ONE for bias slots (x RAM data ignored). Fields hold last value when not valid.
- Writeback: wr_cnt starts at 0. Each i_upd_valid registers o_wr_en=1, o_wr_addr=wr_cnt, o_wr_data=i_new_weight next cycle, then wr_cnt++. Results are in order, so no address FIFO.
- o_done asserts the cycle after the last o_wr_en. o_busy falls the same cycle.
- i_start while busy: ignored.
- i_upd_valid in IDLE: ignored, no write.
- Issue and writeback in the same cycle are independent; both proceed.
- rst mid-operation: abort immediately. Outputs clear next cycle, in-flight datapath results after reset are ignored (state IDLE).
- ISSUE_INTERVAL>1: o_rd_en gaps of ISSUE_INTERVAL-1 cycles. This is required when the datapath cannot hold multiple old weights in flight.

Decomposition:
- Shared package holds the FSM state encoding (IDLE/ISSUE/DRAIN), the ONE constant and DATA_WIDTH default.
- Natural sub-module: weight_index_counter (j/n/k nested counters with wrap and last flag).

Test Plan:
- NUM_INPUTS=2, NUM_NEURONS=2, II=1, model datapath latency 21, start@0 → o_rd_en cycles 1–6 with w addr 0..5, x 0,1,–,0,1,–, d 0,0,0,1,1,1. o_upd_valid 2–7, o_wr_en 24–29 with addr 0..5. o_done@30, o_busy 1..29.
- Bias slots k=2,5 with x RAM=0xDEADBEEF → o_data_point=0x3F800000.
- II=3, same config → o_rd_en at 1,4,7,10,13,16, o_upd_valid one cycle later each, o_done after 6th writeback.
- i_start re-pulsed @5 while busy → no sequence restart, addresses unaffected, single o_done.
- rst asserted @10 → from cycle 11 all outputs 0, IDLE. Model results arriving @23–28 produce no o_wr_en. New start @40 runs a full clean sequence.
- i_upd_valid pulsed in IDLE with data 0x40000000 → o_wr_en stays 0, wr_cnt stays 0.

Source files
------------

// File: rtl/weight_update_scheduler_pkg.sv
// Shared definitions for the weight update scheduler.
//   - FSM state encoding (IDLE / ISSUE / DRAIN)
//   - default float word width and the 1.0 bias data point
//   - helper for sizing counters that must be at least one bit wide
package weight_update_scheduler_pkg;

    localparam int          DATA_WIDTH_DEF = 32;
    localparam logic [31:0] ONE_DEF        = 32'h3F80_0000;

    typedef logic [1:0] sched_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Width needed to hold 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/weight_update_scheduler_if.sv
// Handshake bus between the scheduler and the weight-update point datapath.
//   o_upd_valid / o_old_weight / o_data_point / o_delta : issue to datapath
//   i_upd_valid / i_new_weight                         : in-order result back
// master = scheduler side, slave = datapath side.
interface weight_update_scheduler_if
    import weight_update_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  o_upd_valid;
    logic [DATA_WIDTH-1:0] o_old_weight;
    logic [DATA_WIDTH-1:0] o_data_point;
    logic [DATA_WIDTH-1:0] o_delta;
    logic                  i_upd_valid;
    logic [DATA_WIDTH-1:0] i_new_weight;

    modport master (
        output o_upd_valid, o_old_weight, o_data_point, o_delta,
        input  i_upd_valid, i_new_weight
    );

    modport slave (
        input  o_upd_valid, o_old_weight, o_data_point, o_delta,
        output i_upd_valid, i_new_weight
    );
endinterface

// File: rtl/weight_update_scheduler_index_counter.sv
// weight_index_counter: nested j (input) / n (neuron) counters plus the flat
// weight index k = n*(NUM_INPUTS+1)+j.
//   clk, rst  : clock, synchronous active-high reset
//   adv_i     : step to the next weight slot
//   j_o, n_o  : current input / neuron index
//   k_o       : current flat weight index
//   last_o    : current slot is the final weight of the layer
//   bias_o    : current slot is a bias weight (j == NUM_INPUTS)
module weight_index_counter
    import weight_update_scheduler_pkg::*;
#(
    parameter int NUM_INPUTS   = 4,
    parameter int NUM_NEURONS  = 4,
    parameter int W_ADDR_WIDTH = 5,
    parameter int JW           = 3,
    parameter int NW           = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    adv_i,
    output logic [JW-1:0]           j_o,
    output logic [NW-1:0]           n_o,
    output logic [W_ADDR_WIDTH-1:0] k_o,
    output logic                    last_o,
    output logic                    bias_o
);
    localparam int TOTAL = NUM_NEURONS * (NUM_INPUTS + 1);

    logic [JW-1:0]           j_q;
    logic [NW-1:0]           n_q;
    logic [W_ADDR_WIDTH-1:0] k_q;

    assign last_o = (k_q == W_ADDR_WIDTH'(TOTAL - 1));
    assign bias_o = (j_q == JW'(NUM_INPUTS));
    assign j_o    = j_q;
    assign n_o    = n_q;
    assign k_o    = k_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            j_q <= '0;
            n_q <= '0;
            k_q <= '0;
        end else if (adv_i) begin
            // Wrapping everything after the last slot leaves the counter
            // ready for the next layer update without an explicit clear.
            if (last_o) begin
                j_q <= '0;
                n_q <= '0;
                k_q <= '0;
            end else if (bias_o) begin
                j_q <= '0;
                n_q <= n_q + 1'b1;
                k_q <= k_q + 1'b1;
            end else begin
                j_q <= j_q + 1'b1;
                k_q <= k_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/weight_update_scheduler.sv
// weight_update_scheduler: walks every weight of one layer, reads old weight,
// data point and delta from the layer RAMs, issues one update per slot to the
// weight-update datapath and writes the in-order results back to weight RAM.
//   clk, rst                    : clock, synchronous active-high reset
//   i_start                     : begin layer update (ignored while busy)
//   o_busy / o_done             : busy level / one-cycle completion pulse
//   o_rd_en, o_*_rd_addr        : read strobe and addresses to w/x/d RAMs
//   i_*_rd_data                 : RAM data, valid the cycle after o_rd_en
//   dp (master)                 : issue/result bus to the datapath
//   o_wr_en/o_wr_addr/o_wr_data : weight RAM writeback
module weight_update_scheduler
    import weight_update_scheduler_pkg::*;
#(
    parameter int                    DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int                    NUM_INPUTS     = 4,
    parameter int                    NUM_NEURONS    = 4,
    parameter int                    W_ADDR_WIDTH   = 5,
    parameter int                    X_ADDR_WIDTH   = 3,
    parameter int                    D_ADDR_WIDTH   = 3,
    parameter int                    ISSUE_INTERVAL = 1,
    parameter logic [DATA_WIDTH-1:0] ONE            = DATA_WIDTH'(ONE_DEF)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_rd_en,
    output logic [W_ADDR_WIDTH-1:0] o_w_rd_addr,
    output logic [X_ADDR_WIDTH-1:0] o_x_rd_addr,
    output logic [D_ADDR_WIDTH-1:0] o_d_rd_addr,
    input  logic [DATA_WIDTH-1:0]   i_w_rd_data,
    input  logic [DATA_WIDTH-1:0]   i_x_rd_data,
    input  logic [DATA_WIDTH-1:0]   i_d_rd_data,
    weight_update_scheduler_if.master dp,
    output logic                    o_wr_en,
    output logic [W_ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0]   o_wr_data
);
    localparam int TOTAL = NUM_NEURONS * (NUM_INPUTS + 1);
    localparam int JW    = clog2_min1(NUM_INPUTS + 1);
    localparam int NW    = clog2_min1(NUM_NEURONS);
    localparam int GW    = clog2_min1(ISSUE_INTERVAL);
    // One extra bit so the writeback count can reach TOTAL itself.
    localparam int CW    = W_ADDR_WIDTH + 1;

    localparam logic [CW-1:0] TOTAL_C    = CW'(TOTAL);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(ISSUE_INTERVAL - 1);

    sched_state_t state_q, state_d;
    logic         issue_fire;
    logic         wb_accept;
    logic         wb_finish;

    logic [JW-1:0]           j_idx;
    logic [NW-1:0]           n_idx;
    logic [W_ADDR_WIDTH-1:0] k_idx;
    logic                    k_last;
    logic                    k_bias;

    logic [GW-1:0]           gap_q;
    logic                    rd_en_q;
    logic [W_ADDR_WIDTH-1:0] w_addr_q;
    logic [X_ADDR_WIDTH-1:0] x_addr_q;
    logic [D_ADDR_WIDTH-1:0] d_addr_q;
    logic                    rd_bias_q;

    logic                    upd_valid_q;
    logic                    upd_bias_q;
    logic [DATA_WIDTH-1:0]   old_hold_q;
    logic [DATA_WIDTH-1:0]   dpt_hold_q;
    logic [DATA_WIDTH-1:0]   dlt_hold_q;
    logic [DATA_WIDTH-1:0]   dpt_live;

    logic                    wr_en_q;
    logic [W_ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic [CW-1:0]           wr_cnt_q;
    logic                    done_q;

    weight_index_counter #(
        .NUM_INPUTS  (NUM_INPUTS),
        .NUM_NEURONS (NUM_NEURONS),
        .W_ADDR_WIDTH(W_ADDR_WIDTH),
        .JW          (JW),
        .NW          (NW)
    ) u_idx (
        .clk   (clk),
        .rst   (rst),
        .adv_i (issue_fire),
        .j_o   (j_idx),
        .n_o   (n_idx),
        .k_o   (k_idx),
        .last_o(k_last),
        .bias_o(k_bias)
    );

    // Results only count while a layer update is in progress; stray or
    // post-reset datapath results arriving in IDLE are dropped.
    assign wb_accept = dp.i_upd_valid && (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        issue_fire = 1'b0;
        wb_finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    issue_fire = 1'b1;
                    state_d    = k_last ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (gap_q == '0) begin
                    issue_fire = 1'b1;
                    if (k_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (wr_cnt_q == TOTAL_C) begin
                    wb_finish = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            rd_en_q     <= 1'b0;
            w_addr_q    <= '0;
            x_addr_q    <= '0;
            d_addr_q    <= '0;
            rd_bias_q   <= 1'b0;
            upd_valid_q <= 1'b0;
            upd_bias_q  <= 1'b0;
            old_hold_q  <= '0;
            dpt_hold_q  <= '0;
            dlt_hold_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_cnt_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;

            // Read request stage: one RAM read per issue slot, spaced by
            // ISSUE_INTERVAL cycles via the gap counter.
            rd_en_q <= issue_fire;
            if (issue_fire) begin
                gap_q     <= GAP_RELOAD;
                w_addr_q  <= k_idx;
                x_addr_q  <= X_ADDR_WIDTH'(j_idx);
                d_addr_q  <= D_ADDR_WIDTH'(n_idx);
                rd_bias_q <= k_bias;
            end else if (gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end

            // Issue stage: RAM data lands with upd_valid; capture it so the
            // datapath fields hold their last value between issues.
            upd_valid_q <= rd_en_q;
            upd_bias_q  <= rd_bias_q;
            if (upd_valid_q) begin
                old_hold_q <= i_w_rd_data;
                dpt_hold_q <= dpt_live;
                dlt_hold_q <= i_d_rd_data;
            end

            // Writeback stage: results return in issue order, so the write
            // address is simply the count of results accepted so far.
            wr_en_q <= wb_accept;
            if (wb_accept) begin
                wr_addr_q <= wr_cnt_q[W_ADDR_WIDTH-1:0];
                wr_data_q <= dp.i_new_weight;
            end
            if (wb_finish) begin
                wr_cnt_q <= '0;
            end else if (wb_accept) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            done_q <= wb_finish;
        end
    end

    // Bias slots always multiply by 1.0; the x RAM word read for them is unused.
    assign dpt_live = upd_bias_q ? ONE : i_x_rd_data;

    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = done_q;
    assign o_rd_en     = rd_en_q;
    assign o_w_rd_addr = w_addr_q;
    assign o_x_rd_addr = x_addr_q;
    assign o_d_rd_addr = d_addr_q;

    assign dp.o_upd_valid  = upd_valid_q;
    assign dp.o_old_weight = upd_valid_q ? i_w_rd_data : old_hold_q;
    assign dp.o_data_point = upd_valid_q ? dpt_live    : dpt_hold_q;
    assign dp.o_delta      = upd_valid_q ? i_d_rd_data : dlt_hold_q;

    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
endmodule

// File: tb/tb_weight_update_scheduler.sv
// Bench for weight_update_scheduler: two instances (issue interval 1 and 3)
// share clock and stimulus; each has its own RAM model and a 21-cycle model
// datapath computing new = old + data_point + delta.
module tb_weight_update_scheduler;
    import weight_update_scheduler_pkg::*;

    localparam int          DW    = 32;
    localparam int          NI    = 2;
    localparam int          NN    = 2;
    localparam int          WAW   = 5;
    localparam int          XAW   = 3;
    localparam int          DAW   = 3;
    localparam int          TOTAL = NN * (NI + 1);
    localparam int          LAT   = 21;
    localparam int          A0    = 10;
    localparam logic [31:0] ONE_W = 32'h3F80_0000;
    localparam logic [31:0] INJ_D = 32'h4000_0000;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic inj;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    logic            busy    [2];
    logic            done    [2];
    logic            rd_en   [2];
    logic            wr_en   [2];
    logic [WAW-1:0]  w_addr  [2];
    logic [WAW-1:0]  wr_addr [2];
    logic [XAW-1:0]  x_addr  [2];
    logic [DAW-1:0]  d_addr  [2];
    logic [31:0]     w_rd    [2];
    logic [31:0]     x_rd    [2];
    logic [31:0]     d_rd    [2];
    logic [31:0]     wr_data [2];
    logic            upd_v   [2];
    logic [31:0]     old_w   [2];
    logic [31:0]     dpt     [2];
    logic [31:0]     dlt     [2];
    logic            pv      [2][LAT];
    logic [31:0]     pd      [2][LAT];

    weight_update_scheduler_if #(.DATA_WIDTH(DW)) ifc0 ();
    weight_update_scheduler_if #(.DATA_WIDTH(DW)) ifc1 ();

    assign upd_v[0] = ifc0.o_upd_valid;
    assign old_w[0] = ifc0.o_old_weight;
    assign dpt[0]   = ifc0.o_data_point;
    assign dlt[0]   = ifc0.o_delta;
    assign upd_v[1] = ifc1.o_upd_valid;
    assign old_w[1] = ifc1.o_old_weight;
    assign dpt[1]   = ifc1.o_data_point;
    assign dlt[1]   = ifc1.o_delta;

    assign ifc0.i_upd_valid  = pv[0][LAT-1] | inj;
    assign ifc0.i_new_weight = inj ? INJ_D : pd[0][LAT-1];
    assign ifc1.i_upd_valid  = pv[1][LAT-1] | inj;
    assign ifc1.i_new_weight = inj ? INJ_D : pd[1][LAT-1];

    weight_update_scheduler #(
        .DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_NEURONS(NN), .W_ADDR_WIDTH(WAW),
        .X_ADDR_WIDTH(XAW), .D_ADDR_WIDTH(DAW), .ISSUE_INTERVAL(1), .ONE(ONE_W)
    ) u_dut0 (
        .clk(clk), .rst(rst), .i_start(start), .o_busy(busy[0]), .o_done(done[0]),
        .o_rd_en(rd_en[0]), .o_w_rd_addr(w_addr[0]), .o_x_rd_addr(x_addr[0]),
        .o_d_rd_addr(d_addr[0]), .i_w_rd_data(w_rd[0]), .i_x_rd_data(x_rd[0]),
        .i_d_rd_data(d_rd[0]), .dp(ifc0), .o_wr_en(wr_en[0]),
        .o_wr_addr(wr_addr[0]), .o_wr_data(wr_data[0])
    );

    weight_update_scheduler #(
        .DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_NEURONS(NN), .W_ADDR_WIDTH(WAW),
        .X_ADDR_WIDTH(XAW), .D_ADDR_WIDTH(DAW), .ISSUE_INTERVAL(3), .ONE(ONE_W)
    ) u_dut1 (
        .clk(clk), .rst(rst), .i_start(start), .o_busy(busy[1]), .o_done(done[1]),
        .o_rd_en(rd_en[1]), .o_w_rd_addr(w_addr[1]), .o_x_rd_addr(x_addr[1]),
        .o_d_rd_addr(d_addr[1]), .i_w_rd_data(w_rd[1]), .i_x_rd_data(x_rd[1]),
        .i_d_rd_data(d_rd[1]), .dp(ifc1), .o_wr_en(wr_en[1]),
        .o_wr_addr(wr_addr[1]), .o_wr_data(wr_data[1])
    );

    // Layer memory contents
    function automatic logic [31:0] wmem(input int k);
        return 32'h1000_0000 + 32'(k) * 32'h111;
    endfunction

    function automatic logic [31:0] xmem(input int a);
        case (a)
            0:       return 32'h3F00_0000;
            1:       return 32'h4040_0000;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [31:0] dmem(input int a);
        return (a == 0) ? 32'hBE00_0000 : 32'h3E80_0000;
    endfunction

    function automatic logic [31:0] dpval(input int k);
        return ((k % (NI + 1)) == NI) ? ONE_W : xmem(k % (NI + 1));
    endfunction

    function automatic logic [31:0] newval(input int k);
        return wmem(k) + dpval(k) + dmem(k / (NI + 1));
    endfunction

    // Synchronous-read RAMs and the fixed-latency model datapath
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) begin
                w_rd[i] <= wmem(int'(w_addr[i]));
                x_rd[i] <= xmem(int'(x_addr[i]));
                d_rd[i] <= dmem(int'(d_addr[i]));
            end
            for (int t = LAT - 1; t > 0; t--) begin
                pv[i][t] <= (cyc < 3) ? 1'b0 : pv[i][t-1];
                pd[i][t] <= pd[i][t-1];
            end
            pv[i][0] <= (cyc < 3) ? 1'b0 : upd_v[i];
            pd[i][0] <= old_w[i] + dpt[i] + dlt[i];
        end
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", nm, inst, cyc, act, exp);
        end
    endtask

    // Schedule model: a run accepted at cycle s issues slot k's read at
    // s+1+II*k, presents it to the datapath at s+2+II*k, writes it back at
    // s+24+II*k and pulses done at s+II*(TOTAL-1)+25.
    int          s     [2] = '{-1, -1};
    logic [31:0] h_old [2] = '{32'h0, 32'h0};
    logic [31:0] h_dp  [2] = '{32'h0, 32'h0};
    logic [31:0] h_dl  [2] = '{32'h0, 32'h0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int   ii, rel, kr, kv, kw;
            logic e_rd, e_v, e_wr, e_busy, e_done;
            ii     = (i == 0) ? 1 : 3;
            rel    = (s[i] >= 0) ? (cyc - s[i]) : -1000;
            e_busy = (rel >= 1) && (rel <= ii * (TOTAL - 1) + 24);
            e_done = (rel == ii * (TOTAL - 1) + 25);
            kr     = (rel >= 1)  ? (rel - 1) / ii  : 0;
            kv     = (rel >= 2)  ? (rel - 2) / ii  : 0;
            kw     = (rel >= 24) ? (rel - 24) / ii : 0;
            e_rd   = (rel >= 1)  && (((rel - 1) % ii) == 0)  && (kr < TOTAL);
            e_v    = (rel >= 2)  && (((rel - 2) % ii) == 0)  && (kv < TOTAL);
            e_wr   = (rel >= 24) && (((rel - 24) % ii) == 0) && (kw < TOTAL);

            if (cyc >= 1) begin
                chk("busy", i, 32'(busy[i]), 32'(e_busy));
                chk("done", i, 32'(done[i]), 32'(e_done));
                chk("rd_en", i, 32'(rd_en[i]), 32'(e_rd));
                if (e_rd) begin
                    chk("w_addr", i, 32'(w_addr[i]), 32'(kr));
                    chk("d_addr", i, 32'(d_addr[i]), 32'(kr / (NI + 1)));
                    if ((kr % (NI + 1)) != NI)
                        chk("x_addr", i, 32'(x_addr[i]), 32'(kr % (NI + 1)));
                end
                chk("upd_valid", i, 32'(upd_v[i]), 32'(e_v));
                chk("old_weight", i, old_w[i], e_v ? wmem(kv) : h_old[i]);
                chk("data_point", i, dpt[i], e_v ? dpval(kv) : h_dp[i]);
                chk("delta", i, dlt[i], e_v ? dmem(kv / (NI + 1)) : h_dl[i]);
                chk("wr_en", i, 32'(wr_en[i]), 32'(e_wr));
                if (e_wr) begin
                    chk("wr_addr", i, 32'(wr_addr[i]), 32'(kw));
                    chk("wr_data", i, wr_data[i], newval(kw));
                end
            end

            if (e_v) begin
                h_old[i] = wmem(kv);
                h_dp[i]  = dpval(kv);
                h_dl[i]  = dmem(kv / (NI + 1));
            end

            if (rst) begin
                s[i]     = -1;
                h_old[i] = '0;
                h_dp[i]  = '0;
                h_dl[i]  = '0;
            end else if (start && !e_busy) begin
                s[i] = cyc;
            end
        end

        // Hand-computed anchors for the schedule and data model
        case (cyc)
            A0 + 1: begin
                chk("lit_first_rd", 0, 32'(rd_en[0]), 32'd1);
                chk("lit_first_waddr", 0, 32'(w_addr[0]), 32'd0);
            end
            A0 + 4:  chk("lit_bias_dp", 0, dpt[0], 32'h3F80_0000);
            A0 + 6: begin
                chk("lit_last_waddr", 0, 32'(w_addr[0]), 32'd5);
                chk("lit_last_daddr", 0, 32'(d_addr[0]), 32'd1);
            end
            A0 + 15: chk("lit_ii3_gap", 1, 32'(rd_en[1]), 32'd0);
            A0 + 16: begin
                chk("lit_ii3_rd6", 1, 32'(rd_en[1]), 32'd1);
                chk("lit_ii3_waddr6", 1, 32'(w_addr[1]), 32'd5);
            end
            A0 + 24: begin
                chk("lit_first_wr", 0, 32'(wr_en[0]), 32'd1);
                chk("lit_first_wdata", 0, wr_data[0], 32'h0D00_0000);
            end
            A0 + 29: begin
                chk("lit_last_waddr_wb", 0, 32'(wr_addr[0]), 32'd5);
                chk("lit_last_wdata", 0, wr_data[0], 32'h8E00_0555);
            end
            A0 + 30: begin
                chk("lit_done", 0, 32'(done[0]), 32'd1);
                chk("lit_busy_low", 0, 32'(busy[0]), 32'd0);
            end
            A0 + 40: chk("lit_ii3_done", 1, 32'(done[1]), 32'd1);
            66: begin
                chk("lit_rst_valid", 0, 32'(upd_v[0]), 32'd0);
                chk("lit_rst_busy", 0, 32'(busy[0]), 32'd0);
            end
            79:  chk("lit_rst_no_wr", 0, 32'(wr_en[0]), 32'd0);
            146: begin
                chk("lit_idle_res0", 0, 32'(wr_en[0]), 32'd0);
                chk("lit_idle_res1", 1, 32'(wr_en[1]), 32'd0);
            end
            179: begin
                chk("lit_wrcnt_clean_en", 0, 32'(wr_en[0]), 32'd1);
                chk("lit_wrcnt_clean_addr", 0, 32'(wr_addr[0]), 32'd0);
            end
            default: ;
        endcase
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        inj   = 1'b0;
        wait_cyc(3);      rst   = 1'b0;
        // full run on both instances, with a re-start pulse while busy
        wait_cyc(A0);     start = 1'b1;
        wait_cyc(A0 + 1); start = 1'b0;
        wait_cyc(A0 + 5); start = 1'b1;
        wait_cyc(A0 + 6); start = 1'b0;
        // reset mid-run, then a clean restart
        wait_cyc(55);     start = 1'b1;
        wait_cyc(56);     start = 1'b0;
        wait_cyc(65);     rst   = 1'b1;
        wait_cyc(66);     rst   = 1'b0;
        wait_cyc(95);     start = 1'b1;
        wait_cyc(96);     start = 1'b0;
        // stray datapath result while idle, then another run
        wait_cyc(145);    inj   = 1'b1;
        wait_cyc(146);    inj   = 1'b0;
        wait_cyc(155);    start = 1'b1;
        wait_cyc(156);    start = 1'b0;
        wait_cyc(205);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
